fir_filter: RTL
===============

# fir_filter

Parametrised, time-multiplexed FIR filter with valid/ready sample handshakes and a run-time writable coefficient bank. It sits between the sample source and the FFT/UART back end. It replaces the pass-through filter stage. It computes one output per accepted input sample using a single multiplier-accumulator over TAPS cycles, then rounds, shifts and saturates the result back to the sample width.

## Interface
- DATA_W, 16, signed sample width (input and output)
- COEF_W, 16, signed coefficient width
- TAPS, 16, number of taps (≥2); AW = clog2(TAPS)
- SHIFT, 15, arithmetic right shift applied to accumulator before saturation (0 ≤ SHIFT < ACC_W)
- ACC_W (derived, not overridable), DATA_W+COEF_W+AW

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- inValid  in  1  input sample valid
- inReady  out  1  block can accept a sample
- inSignal  in  DATA_W  signed input sample
- outValid  out  1  filtered sample valid
- outReady  in  1  downstream accepts sample
- outSignal  out  DATA_W  signed filtered sample
- coefWe  in  1  coefficient write strobe
- coefAddr  in  AW  coefficient index k (tap applied to x[n-k])
- coefData  in  COEF_W  signed coefficient value
- clr  in  1  synchronous history flush
- busy  out  1  high in MAC or OUT state

## Operation
- Storage consists of a history ring `hist[TAPS]`, a write pointer `wp`, coefficient bank `coef[TAPS]`, accumulator `acc` (ACC_W, signed), and tap counter `k`.
- The FSM has three states: IDLE, MAC, OUT.
- IDLE: inReady=1 and busy=0. On inValid&&inReady, write `hist[wp]`←inSignal, latch `base`=wp, set `wp`←(wp+1) mod TAPS, clear acc, set k←0, then go to MAC.
- MAC: one product per cycle. acc += coef[k] * hist[(base−k) mod TAPS], with full-precision signed multiply and sign-extension to ACC_W. After k=TAPS−1, go to OUT.
  - The OUT entry edge registers outSignal = sat(rnd(acc)).
  - rnd: if SHIFT>0, add 2^(SHIFT−1), then arithmetic shift right by SHIFT (ties round toward +∞). If SHIFT=0, no rounding is applied.
  - sat: clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- OUT: outValid=1. outSignal stays stable until outValid&&outReady, then go to IDLE.
- Coefficients are writable only in IDLE. coefWe in MAC or OUT is ignored, with no deferred write. In IDLE, a write lands on the next edge. If the write coincides with a sample accept, it takes effect before the MAC cycles read the bank.
- clr is honoured in any state and has priority over accept and coefWe. It zeroes hist, sets wp←0, drops any pending output (outValid←0) and forces IDLE. Coefficients are untouched.
- rst low (asynchronous) forces the following immediately: IDLE, hist all 0, coef all 0, wp=0, acc=0, k=0, outValid=0, outSignal=0, busy=0. inReady reads 1 after release.

## Timing
- Accept edge E0 → MAC cycles on edges E1..E_TAPS → outValid high after edge E_TAPS. Latency is TAPS cycles from accept to outValid.
- outValid deasserts on the edge where outReady is sampled high. inReady reasserts on that same edge (IDLE).
- Minimum spacing between accepts is TAPS+2 cycles, when outReady is held high.
- inReady=0 in MAC and OUT. inValid is ignored there and the sample is not stored.
- Pointer wrap: wp and (base−k) are computed modulo TAPS. They must be correct for non-power-of-two TAPS.
- Reset mid-MAC or mid-OUT: the result is discarded and there is no spurious outValid pulse after release.

## Test plan
Bench parameters: TAPS=4, DATA_W=16, COEF_W=16.
- **Impulse:** SHIFT=0, coef={1,2,3,4}, inputs 1,0,0,0,0 → outputs 1,2,3,4,0. Each outValid arrives 4 cycles after its accept.
- **Moving average:** SHIFT=15, coef all 8192, inputs 4000×4 → outputs 1000,2000,3000,4000.
- **Saturation:** SHIFT=0, coef={32767,0,0,0}:
  - input 32767 → 32767
  - input −32768 → −32768
  - input 2 → 32767
- **Backpressure:** outReady low for 10 cycles after outValid → outSignal constant, outValid held, inReady=0, and inValid pulses are ignored. When outReady goes high, exactly one handshake occurs, then IDLE.
- **Reset and clr mid-operation:**
  - rst low during MAC → outValid stays 0. After release, impulse with rewritten coefs {1,2,3,4} yields 1,2,3,4.
  - clr in OUT → outValid drops next edge. Next impulse response shows no residue from prior samples.
- **Blocked coef write:** coefWe (addr 0, data 100) asserted during MAC and OUT → coef[0] unchanged; verify with an impulse.

Source files
------------

// File: rtl/fir_filter.sv
// Time-multiplexed FIR filter: one multiply-accumulate per cycle over Taps cycles per
// accepted sample, then round, shift and saturate back to the sample width.
module fir_filter #(
  parameter int unsigned DataW = 16,
  parameter int unsigned CoefW = 16,
  parameter int unsigned Taps  = 16,
  parameter int unsigned Shift = 15,
  localparam int unsigned Aw   = $clog2(Taps),
  localparam int unsigned AccW = DataW + CoefW + Aw
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [DataW-1:0] in_signal_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [DataW-1:0] out_signal_o,
  input  logic                    coef_we_i,
  input  logic [Aw-1:0]           coef_addr_i,
  input  logic signed [CoefW-1:0] coef_data_i,
  input  logic                    clr_i,
  output logic                    busy_o
);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  localparam int unsigned ProdW = DataW + CoefW;

  // Rounding constant and saturation bounds, all at accumulator width plus one guard bit.
  localparam logic signed [AccW:0] RndAdd =
      (Shift > 0) ? ((AccW + 1)'(1) << (Shift - 1)) : '0;
  localparam logic signed [AccW:0] SatMax =
      {{(AccW + 2 - DataW){1'b0}}, {(DataW - 1){1'b1}}};
  localparam logic signed [AccW:0] SatMin =
      {{(AccW + 2 - DataW){1'b1}}, {(DataW - 1){1'b0}}};

  state_e                  state_q, state_d;
  logic signed [DataW-1:0] hist_q [Taps];
  logic signed [DataW-1:0] hist_d [Taps];
  logic signed [CoefW-1:0] coef_q [Taps];
  logic signed [CoefW-1:0] coef_d [Taps];
  logic [Aw-1:0]           wp_q, wp_d;
  logic [Aw-1:0]           base_q, base_d;
  logic [Aw-1:0]           k_q, k_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic signed [DataW-1:0] out_q, out_d;

  logic [Aw:0]             idx_w;
  logic [Aw-1:0]           rd_idx;
  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  acc_sum;
  logic signed [AccW:0]    acc_ext;
  logic signed [AccW:0]    rnd_val;
  logic signed [DataW-1:0] sat_val;

  // Datapath: history index (base - k) mod Taps, product, running sum, round and saturate.
  always_comb begin
    idx_w = {1'b0, base_q} + (Aw + 1)'(Taps) - {1'b0, k_q};
    if (idx_w >= (Aw + 1)'(Taps)) begin
      idx_w = idx_w - (Aw + 1)'(Taps);
    end
    rd_idx  = idx_w[Aw-1:0];
    prod    = coef_q[k_q] * hist_q[rd_idx];
    acc_sum = acc_q + {{Aw{prod[ProdW-1]}}, prod};
    acc_ext = {acc_sum[AccW-1], acc_sum};
    rnd_val = (acc_ext + RndAdd) >>> Shift;
    if (rnd_val > SatMax) begin
      sat_val = SatMax[DataW-1:0];
    end else if (rnd_val < SatMin) begin
      sat_val = SatMin[DataW-1:0];
    end else begin
      sat_val = rnd_val[DataW-1:0];
    end
  end

  // Next-state logic; clr overrides accept and coefficient writes in every state.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    coef_d  = coef_q;
    wp_d    = wp_q;
    base_d  = base_q;
    k_d     = k_q;
    acc_d   = acc_q;
    out_d   = out_q;
    if (clr_i) begin
      hist_d  = '{default: '0};
      wp_d    = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Out-of-range addresses (non-power-of-two Taps) are dropped.
          if (coef_we_i && ({1'b0, coef_addr_i} < (Aw + 1)'(Taps))) begin
            coef_d[coef_addr_i] = coef_data_i;
          end
          if (in_valid_i) begin
            hist_d[wp_q] = in_signal_i;
            base_d       = wp_q;
            wp_d         = (wp_q == Aw'(Taps - 1)) ? '0 : wp_q + 1'b1;
            acc_d        = '0;
            k_d          = '0;
            state_d      = StMac;
          end
        end
        StMac: begin
          acc_d = acc_sum;
          if (k_q == Aw'(Taps - 1)) begin
            out_d   = sat_val;
            state_d = StOut;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        StOut: begin
          if (out_ready_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      hist_q  <= '{default: '0};
      coef_q  <= '{default: '0};
      wp_q    <= '0;
      base_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      coef_q  <= coef_d;
      wp_q    <= wp_d;
      base_q  <= base_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready_o   = (state_q == StIdle);
    out_valid_o  = (state_q == StOut);
    busy_o       = (state_q != StIdle);
    out_signal_o = out_q;
  end

endmodule
